// File: rtl/float_pool_pkg.sv
// Shared types and constants for the float pooling datapath: default field widths,
// field positions, FSM state encoding and the canonical quiet-NaN pattern.
package float_pool_pkg;

  localparam int EXP_BITS_DEF  = 8;
  localparam int MAN_BITS_DEF  = 23;
  localparam int MAN_LSB       = 0;
  localparam int EXP_LSB_DEF   = MAN_BITS_DEF;
  localparam int SIGN_POS_DEF  = EXP_BITS_DEF + MAN_BITS_DEF;
  localparam int QNAN_MAX_BITS = 128;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Positive sign, all-ones exponent, mantissa MSB set; caller truncates to its word width.
  function automatic logic [QNAN_MAX_BITS-1:0] canon_qnan(input int exp_bits, input int man_bits);
    logic [QNAN_MAX_BITS-1:0] v;
    v = '0;
    for (int i = 0; i < exp_bits; i++) begin
      v[man_bits + i] = 1'b1;
    end
    v[man_bits - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/float_order_sel.sv
// Combinational sign-magnitude ordering of two floats: returns the greater (or lesser
// when mode_min_i) operand, keeping acc_i on a bit-identical tie, and flags a NaN candidate.
module float_order_sel
  import float_pool_pkg::*;
#(
  parameter int EXP_BITS = EXP_BITS_DEF,
  parameter int MAN_BITS = MAN_BITS_DEF
) (
  input  logic [EXP_BITS+MAN_BITS:0] acc_i,
  input  logic [EXP_BITS+MAN_BITS:0] cand_i,
  input  logic                       mode_min_i,
  output logic [EXP_BITS+MAN_BITS:0] sel_o,
  output logic                       cand_is_nan_o
);

  localparam int MAG_BITS = EXP_BITS + MAN_BITS;

  logic                acc_sign;
  logic                cand_sign;
  logic [MAG_BITS-1:0] acc_mag;
  logic [MAG_BITS-1:0] cand_mag;
  logic                cand_gt;
  logic                cand_lt;

  assign acc_sign  = acc_i[MAG_BITS];
  assign cand_sign = cand_i[MAG_BITS];
  assign acc_mag   = acc_i[MAG_BITS-1:0];
  assign cand_mag  = cand_i[MAG_BITS-1:0];

  // Differing signs decide on sign alone, which also orders +0 above -0.
  always_comb begin
    cand_gt = 1'b0;
    cand_lt = 1'b0;
    if (acc_sign != cand_sign) begin
      cand_gt = !cand_sign;
      cand_lt = cand_sign;
    end else if (!cand_sign) begin
      cand_gt = cand_mag > acc_mag;
      cand_lt = cand_mag < acc_mag;
    end else begin
      cand_gt = cand_mag < acc_mag;
      cand_lt = cand_mag > acc_mag;
    end
  end

  assign sel_o         = (mode_min_i ? cand_lt : cand_gt) ? cand_i : acc_i;
  assign cand_is_nan_o = (&cand_i[MAG_BITS-1:MAN_BITS]) && (|cand_i[MAN_BITS-1:MAN_LSB]);

endmodule

// File: rtl/float_pool_stream.sv
// Reduces WINDOW channel-interleaved samples per channel to one MAX/MIN result, then drains
// CHANNELS results in order; first result the cycle after the last input, input stalled while draining.
module float_pool_stream
  import float_pool_pkg::*;
#(
  parameter int EXP_BITS = EXP_BITS_DEF,
  parameter int MAN_BITS = MAN_BITS_DEF,
  parameter int WINDOW   = 4,
  parameter int CHANNELS = 2,
  localparam int DATA_BITS = 1 + EXP_BITS + MAN_BITS,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode_min,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_BITS-1:0] out_data,
  output logic [CH_W-1:0]      out_channel,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int                   WIN_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CH_W-1:0]      LAST_CH   = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0]      PENULT_CH = CH_W'(CHANNELS - 2);
  localparam logic [WIN_W-1:0]     LAST_WIN  = WIN_W'(WINDOW - 1);
  localparam logic [DATA_BITS-1:0] QNAN      = DATA_BITS'(canon_qnan(EXP_BITS, MAN_BITS));

  state_e               state_q;
  logic [CH_W-1:0]      chan_q;
  logic [WIN_W-1:0]     win_q;
  logic                 mode_q;
  logic [DATA_BITS-1:0] acc_q [CHANNELS];
  logic [CHANNELS-1:0]  nan_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [CH_W-1:0]      out_channel_q;

  logic [DATA_BITS-1:0] sel;
  logic                 cand_is_nan;
  logic                 in_beat;
  logic                 out_beat;

  assign in_beat  = in_valid && in_ready_q;
  assign out_beat = out_valid_q && out_ready;

  float_order_sel #(
    .EXP_BITS (EXP_BITS),
    .MAN_BITS (MAN_BITS)
  ) u_order_sel (
    .acc_i         (acc_q[chan_q]),
    .cand_i        (in_data),
    .mode_min_i    (mode_q),
    .sel_o         (sel),
    .cand_is_nan_o (cand_is_nan)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACCUM;
      chan_q        <= '0;
      win_q         <= '0;
      mode_q        <= 1'b0;
      nan_q         <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_channel_q <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_beat) begin
            // First window slot seeds the accumulator; the pool's ordering is fixed here too.
            if (win_q == '0) begin
              acc_q[chan_q] <= in_data;
              nan_q[chan_q] <= cand_is_nan;
              if (chan_q == '0) begin
                mode_q <= mode_min;
              end
            end else begin
              acc_q[chan_q] <= sel;
              nan_q[chan_q] <= nan_q[chan_q] | cand_is_nan;
            end
            if (chan_q == LAST_CH) begin
              chan_q <= '0;
              if (win_q == LAST_WIN) begin
                win_q         <= '0;
                state_q       <= DRAIN;
                in_ready_q    <= 1'b0;
                out_valid_q   <= 1'b1;
                out_channel_q <= '0;
                out_last_q    <= (CHANNELS == 1);
              end else begin
                win_q <= win_q + WIN_W'(1);
              end
            end else begin
              chan_q <= chan_q + CH_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_beat) begin
            if (out_channel_q == LAST_CH) begin
              state_q       <= ACCUM;
              in_ready_q    <= 1'b1;
              out_valid_q   <= 1'b0;
              out_channel_q <= '0;
              out_last_q    <= 1'b0;
            end else begin
              out_channel_q <= out_channel_q + CH_W'(1);
              out_last_q    <= (out_channel_q == PENULT_CH);
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  // Accumulators are frozen in DRAIN, so the result mux is stable under backpressure.
  assign out_data    = nan_q[out_channel_q] ? QNAN : acc_q[out_channel_q];
  assign out_channel = out_channel_q;
  assign out_last    = out_last_q;
  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;

endmodule
